// File: rtl/predecode_iq_if.sv
// Fetch-to-decode handshake between fetch, the predecode queue and decode, plus the early redirect.
// The fetch/decode side uses master. The queue uses slave.
interface predecode_iq_if;
    logic        flush;
    logic        FpD_valid;
    logic [74:0] FpD_BUS;
    logic        pD_allowin;
    logic        pDD_valid;
    logic [74:0] pDD_BUS;
    logic        D_allowin;
    logic [32:0] Branch_BUS_pD;

    modport master (
        output flush, FpD_valid, FpD_BUS, D_allowin,
        input  pD_allowin, pDD_valid, pDD_BUS, Branch_BUS_pD
    );

    modport slave (
        input  flush, FpD_valid, FpD_BUS, D_allowin,
        output pD_allowin, pDD_valid, pDD_BUS, Branch_BUS_pD
    );
endinterface

// File: rtl/predecode_iq.sv
// Instruction queue with direct-branch predecode and a one-cycle early redirect. Entries are visible 1 cycle after accept.
// pD_allowin drops when the queue is full or during flush; a full queue has no dequeue bypass.
module predecode_iq #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    predecode_iq_if.slave iq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pc_en;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
    } fetch_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
        logic        is_dirbr;
    } entry_t;

    typedef enum logic {NORMAL, WAIT_TGT} state_t;

    fetch_t        in;
    entry_t        in_entry;
    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    state_t        state;
    logic          taken;
    logic [31:0]   tgt;
    logic          accept;
    logic          deq;
    logic          store;
    logic          is_dirbr;
    logic [27:0]   offs;
    logic [31:0]   br_tgt;
    logic          unused_pc_en;

    assign in           = fetch_t'(iq.FpD_BUS);
    assign unused_pc_en = in.pc_en;

    assign iq.pD_allowin    = (count != CW'(DEPTH)) & ~iq.flush;
    assign iq.pDD_valid     = (count != '0);
    assign iq.pDD_BUS       = mem[head];
    assign iq.Branch_BUS_pD = {taken, tgt};

    assign accept = iq.FpD_valid & iq.pD_allowin;
    assign deq    = iq.pDD_valid & iq.D_allowin;

    assign is_dirbr = ~in.ex & ((in.inst[31:26] == 6'b010100) | (in.inst[31:26] == 6'b010101));
    assign offs     = {in.inst[9:0], in.inst[25:10], 2'b00};
    assign br_tgt   = in.pc + {{4{offs[27]}}, offs};

    // While a redirect is in flight, fetch still delivers wrong-path entries; only the target pc is kept.
    assign store = accept & ((state == NORMAL) | (in.pc == tgt));

    assign in_entry = '{pc:       in.pc,
                        inst:     in.inst,
                        ex:       in.ex,
                        ecode:    in.ecode,
                        esubcode: in.esubcode,
                        is_dirbr: is_dirbr};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= NORMAL;
            taken <= 1'b0;
            tgt   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (iq.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= NORMAL;
            taken <= 1'b0;
        end else begin
            taken <= 1'b0;
            if (store) begin
                mem[tail] <= in_entry;
                tail      <= tail + PW'(1);
                if (is_dirbr) begin
                    state <= WAIT_TGT;
                    tgt   <= br_tgt;
                    taken <= 1'b1;
                end else begin
                    state <= NORMAL;
                end
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(store) - CW'(deq);
        end
    end
endmodule

// File: tb/tb_predecode_iq.sv
// Scoreboard bench for predecode_iq: a behavioural model predicts stored entries and redirects; a monitor compares.
module tb_predecode_iq;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    predecode_iq_if bus_if ();
    predecode_iq #(.DEPTH(DEPTH)) dut (.clk(clk), .rstn(rstn), .iq(bus_if));

    int          total = 0;
    int          bad   = 0;
    logic [74:0] exp_q[$];
    int          m_cnt;
    bit          m_wait;
    logic [31:0] m_tgt;
    bit          exp_taken;
    bit          last_acc;

    function automatic logic [74:0] fbus(logic [31:0] pc, logic [31:0] inst, bit ex, logic [7:0] ec, bit es);
        return {pc, inst, 1'b1, ex, ec, es};
    endfunction

    function automatic bit ref_dirbr(logic [31:0] inst, bit ex);
        int op;
        op = int'(inst >> 26);
        return !ex && (op == 20 || op == 21);
    endfunction

    function automatic logic [31:0] ref_tgt(logic [31:0] pc, logic [31:0] inst);
        logic [25:0] imm;
        int          words;
        imm   = {inst[9:0], inst[25:10]};
        words = (int'(imm) >= (1 << 25)) ? int'(imm) - (1 << 26) : int'(imm);
        return pc + 32'(words * 4);
    endfunction

    task automatic chk(string name, logic [74:0] act, logic [74:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: evaluated on every rising edge from the inputs held since the previous edge.
    initial begin
        forever begin
            logic [74:0] b;
            logic [31:0] pc, inst;
            bit          ex, acc, deq, st, br;
            @(posedge clk);
            b = bus_if.FpD_BUS;
            if (rstn !== 1'b1) begin
                m_cnt = 0; m_wait = 0; m_tgt = '0; exp_taken = 0; last_acc = 0;
                exp_q.delete();
            end else begin
                acc      = bus_if.FpD_valid && (m_cnt != DEPTH) && !bus_if.flush;
                last_acc = acc;
                if (bus_if.flush) begin
                    m_cnt = 0; m_wait = 0; exp_taken = 0;
                    exp_q.delete();
                end else begin
                    pc   = b[74:43];
                    inst = b[42:11];
                    ex   = b[9];
                    deq  = (m_cnt != 0) && bus_if.D_allowin;
                    st   = acc && (!m_wait || pc == m_tgt);
                    br   = ref_dirbr(inst, ex);
                    exp_taken = 0;
                    if (st) begin
                        exp_q.push_back({pc, inst, ex, b[8:1], b[0], br});
                        m_cnt++;
                        m_wait = br;
                        if (br) begin
                            m_tgt     = ref_tgt(pc, inst);
                            exp_taken = 1;
                        end
                    end
                    if (deq) m_cnt--;
                end
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and pops the scoreboard on each dequeue.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                chk("allowin", bus_if.pD_allowin, (m_cnt != DEPTH) && !bus_if.flush);
                chk("valid", bus_if.pDD_valid, exp_q.size() != 0);
                chk("branch_bus", bus_if.Branch_BUS_pD, {exp_taken, m_tgt});
                if (bus_if.pDD_valid && bus_if.D_allowin && !bus_if.flush && exp_q.size() != 0)
                    chk("head_entry", bus_if.pDD_BUS, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        bus_if.FpD_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic push(logic [74:0] b);
        bus_if.FpD_BUS   = b;
        bus_if.FpD_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (last_acc) begin
                bus_if.FpD_valid = 1'b0;
                return;
            end
        end
        bus_if.FpD_valid = 1'b0;
        total++;
        bad++;
        $display("FAIL push_timeout: got no accept, expected accept within 200 cycles");
    endtask

    localparam logic [31:0] NOP = 32'h0280_0000;

    initial begin
        rstn             = 1'b0;
        bus_if.flush     = 1'b0;
        bus_if.FpD_valid = 1'b0;
        bus_if.FpD_BUS   = '0;
        bus_if.D_allowin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("reset_bus", bus_if.pDD_BUS, 75'd0);
        chk("reset_valid", bus_if.pDD_valid, 1'b0);
        chk("reset_branch", bus_if.Branch_BUS_pD, 33'd0);
        step();

        // streaming
        bus_if.D_allowin = 1'b1;
        for (int k = 0; k < 6; k++) push(fbus(32'h1c00_0000 + 32'(4 * k), NOP + 32'(k), 0, 8'h00, 0));
        idle(3);

        // full queue and backpressure
        bus_if.D_allowin = 1'b0;
        for (int k = 0; k < 4; k++) push(fbus(32'h1c00_0100 + 32'(4 * k), NOP, 0, 8'h00, 0));
        bus_if.FpD_BUS   = fbus(32'h1c00_0110, NOP, 0, 8'h00, 0);
        bus_if.FpD_valid = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("full_allowin", bus_if.pD_allowin, 1'b0);
        step();
        bus_if.D_allowin = 1'b1;
        push(fbus(32'h1c00_0110, NOP, 0, 8'h00, 0));
        idle(8);

        // forward B: wrong-path entries dropped until target
        push(fbus(32'h1c00_0010, 32'h5000_2000, 0, 8'h00, 0));
        @(negedge clk);
        chk("b_redirect", bus_if.Branch_BUS_pD, {1'b1, 32'h1c00_0030});
        step();
        push(fbus(32'h1c00_0014, NOP, 0, 8'h00, 0));
        push(fbus(32'h1c00_0018, NOP, 0, 8'h00, 0));
        push(fbus(32'h1c00_0030, NOP, 0, 8'h00, 0));
        push(fbus(32'h1c00_0200, NOP, 0, 8'h00, 0));
        idle(4);

        // backward BL wrapping below zero
        push(fbus(32'h0000_0004, 32'h57ff_fbff, 0, 8'h00, 0));
        @(negedge clk);
        chk("bl_redirect", bus_if.Branch_BUS_pD, {1'b1, 32'hffff_fffc});
        chk("bl_dirbr", bus_if.pDD_BUS[0], 1'b1);
        step();
        push(fbus(32'hffff_fffc, NOP, 0, 8'h00, 0));
        idle(4);

        // flush collides with enqueue of a branch, dequeue and pending redirect
        bus_if.D_allowin = 1'b0;
        push(fbus(32'h0000_0100, NOP, 0, 8'h00, 0));
        push(fbus(32'h0000_0104, NOP, 0, 8'h00, 0));
        push(fbus(32'h0000_0108, 32'h5000_2000, 0, 8'h00, 0));
        bus_if.FpD_BUS   = fbus(32'h0000_0128, 32'h5000_2000, 0, 8'h00, 0);
        bus_if.FpD_valid = 1'b1;
        bus_if.D_allowin = 1'b1;
        bus_if.flush     = 1'b1;
        step();
        bus_if.flush     = 1'b0;
        bus_if.FpD_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", bus_if.pDD_valid, 1'b0);
        chk("flush_pulse", bus_if.Branch_BUS_pD[32], 1'b0);
        step();
        push(fbus(32'h0000_0300, NOP, 0, 8'h00, 0));
        idle(3);

        // exception entry carrying a B encoding
        push(fbus(32'h1c00_0500, 32'h5000_2000, 1, 8'h08, 0));
        @(negedge clk);
        chk("ex_pulse", bus_if.Branch_BUS_pD[32], 1'b0);
        chk("ex_ecode", bus_if.pDD_BUS[9:2], 8'h08);
        chk("ex_dirbr", bus_if.pDD_BUS[0], 1'b0);
        step();
        idle(3);

        // reset mid-stream drops entries and pending redirect
        bus_if.D_allowin = 1'b0;
        push(fbus(32'h0000_0400, 32'h5000_2000, 0, 8'h00, 0));
        push(fbus(32'h0000_0420, NOP, 0, 8'h00, 0));
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", bus_if.pDD_valid, 1'b0);
        step();
        bus_if.D_allowin = 1'b1;
        push(fbus(32'h0000_0404, NOP, 0, 8'h00, 0));
        idle(3);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] pc, inst;
            pc   = (m_wait && ($urandom % 2 == 0)) ? m_tgt : ($urandom & 32'hffff_fffc);
            inst = ($urandom % 3 == 0) ? {5'b01010, 1'($urandom), 26'($urandom)} : $urandom;
            bus_if.FpD_BUS   = fbus(pc, inst, ($urandom % 10) == 0, 8'($urandom), 1'($urandom));
            bus_if.FpD_valid = ($urandom % 3) != 0;
            bus_if.D_allowin = ($urandom % 4) != 0;
            bus_if.flush     = ($urandom % 40) == 0;
            step();
        end
        bus_if.flush     = 1'b0;
        bus_if.D_allowin = 1'b1;
        idle(10);
        chk("drained", 75'(exp_q.size()), 75'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
